// File: rtl/ternary_serial_subtractor.sv
// Bit-serial unsigned ternary subtractor: diff = (A - B - Bin) mod 3^NTRITS, one trit per clock, LSB first.
// Trit encoding 2'b00/01/10 = 0/1/2; 2'b11 is illegal and yields err with zeroed results.
module ternary_serial_subtractor #(
    parameter int NTRITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*NTRITS-1:0]   a,
    input  logic [2*NTRITS-1:0]   b,
    input  logic [1:0]            b_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NTRITS-1:0]   diff,
    output logic [1:0]            b_out,
    output logic                  err
);
    localparam int IW = (NTRITS > 1) ? $clog2(NTRITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [2*NTRITS-1:0]   a_q, a_d, b_q, b_d;
    logic                  borrow_q, borrow_d;
    logic [2*NTRITS-1:0]   diff_q, diff_d;
    logic [1:0]            bout_q, bout_d;
    logic                  err_q, err_d;

    logic [2*NTRITS-1:0]   a_sh, b_sh;
    logic [1:0]            ak, bk, dk;
    logic [3:0]            sub;
    logic                  nb;

    function automatic logic illegal_f(input logic [2*NTRITS-1:0] av,
                                       input logic [2*NTRITS-1:0] bv,
                                       input logic [1:0]          bi);
        logic bad;
        bad = bi[1];
        for (int k = 0; k < NTRITS; k++) begin
            if (av[2*k +: 2] == 2'b11 || bv[2*k +: 2] == 2'b11) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            err_q    <= err_d;
        end
    end

    // Current trit step: sub = t + 3, so t < 0 exactly when sub < 3.
    always_comb begin
        a_sh = a_q >> {idx_q, 1'b0};
        b_sh = b_q >> {idx_q, 1'b0};
        ak   = a_sh[1:0];
        bk   = b_sh[1:0];
        sub  = {2'b00, ak} + 4'd3 - {2'b00, bk} - {3'b000, borrow_q};
        nb   = (sub < 4'd3);
        dk   = nb ? sub[1:0] : 2'(sub - 4'd3);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        borrow_d  = borrow_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        err_d     = err_q;
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = b_in[0];
                    idx_d    = '0;
                    diff_d   = '0;
                    bout_d   = 2'b00;
                    err_d    = illegal_f(a, b, b_in);
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Illegal operands still take the full latency, with results left at zero.
                if (!err_q) begin
                    for (int k = 0; k < NTRITS; k++) begin
                        if (idx_q == IW'(k)) diff_d[2*k +: 2] = dk;
                    end
                end
                borrow_d = nb;
                if (idx_q == IW'(NTRITS - 1)) begin
                    idx_d   = '0;
                    bout_d  = err_q ? 2'b00 : {1'b0, nb};
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign diff  = diff_q;
    assign b_out = bout_q;
    assign err   = err_q;

endmodule
